// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roller slice.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPIN    = 2'd1,
    SLOW    = 2'd2,
    SETTLED = 2'd3
  } state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // LED bit positions in each die's 7-bit pip field
  localparam int PIP_TL = 0;
  localparam int PIP_ML = 1;
  localparam int PIP_BL = 2;
  localparam int PIP_MC = 3;
  localparam int PIP_TR = 4;
  localparam int PIP_MR = 5;
  localparam int PIP_BR = 6;

  // Next face with wrap back to 1; anything at or above faces wraps too.
  function automatic logic [2:0] face_inc(input logic [2:0] v, input logic [2:0] faces);
    return (v >= faces) ? 3'd1 : v + 3'd1;
  endfunction

endpackage

// File: rtl/dice_roller_pip_encoder.sv
// Die face value to 7-LED pip pattern, purely combinational.
module pip_encoder
  import dice_pkg::*;
(
  input  logic [2:0] value,
  output logic [6:0] leds
);

  // Decode one face; unused codes light nothing.
  always_comb begin
    leds = '0;
    case (value)
      3'd1: leds[PIP_MC] = 1'b1;
      3'd2: begin
        leds[PIP_TL] = 1'b1;
        leds[PIP_BR] = 1'b1;
      end
      3'd3: begin
        leds[PIP_TL] = 1'b1;
        leds[PIP_MC] = 1'b1;
        leds[PIP_BR] = 1'b1;
      end
      3'd4, 3'd5: begin
        leds[PIP_TL] = 1'b1;
        leds[PIP_TR] = 1'b1;
        leds[PIP_BL] = 1'b1;
        leds[PIP_BR] = 1'b1;
        leds[PIP_MC] = (value == 3'd5);
      end
      3'd6: begin
        leds[PIP_TL] = 1'b1;
        leds[PIP_ML] = 1'b1;
        leds[PIP_BL] = 1'b1;
        leds[PIP_TR] = 1'b1;
        leds[PIP_MR] = 1'b1;
        leds[PIP_BR] = 1'b1;
      end
      default: leds = '0;
    endcase
  end

endmodule

// File: rtl/dice_roller.sv
// Multi-die roller: spin while Roll is held, decelerate geometrically on
// release, then freeze with Settled. Dice step on a shared tick, each gated
// by its own LFSR bit so they drift apart.
module dice_roller
  import dice_pkg::*;
#(
  parameter int          NUM_DICE   = 2,
  parameter int          FACES      = 6,
  parameter int          SPIN_DIV   = 4,
  parameter int          SLOW_STEPS = 3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Roll,
  output logic [3*NUM_DICE-1:0] Values,
  output logic [7*NUM_DICE-1:0] Pips,
  output logic                  Rolling,
  output logic                  Settled
);

  // Longest period is the final slow step, SPIN_DIV << SLOW_STEPS.
  localparam int         PW      = $clog2((SPIN_DIV << SLOW_STEPS) + 1);
  localparam int         SW      = $clog2(SLOW_STEPS + 1);
  localparam logic [PW-1:0] SPIN_P = PW'(SPIN_DIV);
  localparam logic [2:0] FACES_3 = 3'(FACES);

  if (FACES > 6 || FACES < 2) begin : g_bad_faces
    $error("dice_roller: FACES must be 2..6");
  end
  if (NUM_DICE > 8 || NUM_DICE < 1) begin : g_bad_dice
    $error("dice_roller: NUM_DICE must be 1..8");
  end
  if (SEED == 16'h0000) begin : g_bad_seed
    $error("dice_roller: SEED must be nonzero");
  end

  state_e                      state;
  logic [LFSR_W-1:0]           lfsr;
  logic [PW-1:0]               cnt;
  logic [PW-1:0]               period;
  logic [SW-1:0]               steps;
  logic [NUM_DICE-1:0][2:0]    val;
  logic                        tick;

  assign tick   = (cnt == period - PW'(1));
  assign Values = val;

  // Free-running LFSR, reloaded only by reset.
  always_ff @(posedge Clock) begin
    if (Reset) lfsr <= SEED;
    else       lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
  end

  // FSM, tick counter, period/step bookkeeping and dice values.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      period  <= SPIN_P;
      steps   <= '0;
      val     <= {NUM_DICE{3'd1}};
      Rolling <= 1'b0;
      Settled <= 1'b0;
    end else begin
      if ((state == SPIN || state == SLOW) && tick) begin
        for (int i = 0; i < NUM_DICE; i++)
          if (lfsr[i]) val[i] <= face_inc(val[i], FACES_3);
      end
      cnt <= tick ? '0 : cnt + PW'(1);
      case (state)
        IDLE, SETTLED: begin
          cnt <= '0;
          if (Roll) begin
            state   <= SPIN;
            period  <= SPIN_P;
            Rolling <= 1'b1;
            Settled <= 1'b0;
          end
        end
        SPIN: begin
          if (!Roll) begin
            state  <= SLOW;
            period <= SPIN_P << 1;
            steps  <= '0;
            cnt    <= '0;
          end
        end
        SLOW: begin
          // A new Roll wins over a coincident final tick.
          if (Roll) begin
            state  <= SPIN;
            period <= SPIN_P;
            cnt    <= '0;
          end else if (tick) begin
            steps <= steps + SW'(1);
            if (steps == SW'(SLOW_STEPS - 1)) begin
              state   <= SETTLED;
              Rolling <= 1'b0;
              Settled <= 1'b1;
            end else begin
              period <= period << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_DICE; g++) begin : g_die
    pip_encoder u_pip (
      .value (val[g]),
      .leds  (Pips[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_dice_roller.sv
// Bench for dice_roller: behavioural model plus directed literal checks,
// and a second FACES=3 instance watched for range and pip legality.
module tb_dice_roller;

  logic        clk = 1'b0;
  logic        rst, roll, roll3;
  logic [5:0]  values, values3;
  logic [13:0] pips, pips3;
  logic        rolling, settled, rolling3, settled3;

  always #5 clk = ~clk;

  dice_roller #(.NUM_DICE(2), .FACES(6), .SPIN_DIV(4), .SLOW_STEPS(3), .SEED(16'hACE1)) dut (
    .Clock(clk), .Reset(rst), .Roll(roll), .Values(values), .Pips(pips),
    .Rolling(rolling), .Settled(settled));

  dice_roller #(.NUM_DICE(2), .FACES(3), .SPIN_DIV(4), .SLOW_STEPS(3), .SEED(16'hACE1)) dut3 (
    .Clock(clk), .Reset(rst), .Roll(roll3), .Values(values3), .Pips(pips3),
    .Rolling(rolling3), .Settled(settled3));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [6:0] pipof(input int v);
    case (v)
      1: return 7'b0001000;
      2: return 7'b1000001;
      3: return 7'b1001001;
      4: return 7'b1010101;
      5: return 7'b1011101;
      6: return 7'b1110111;
      default: return 7'b0000000;
    endcase
  endfunction

  // Behavioural model: phase 0 idle, 1 spin, 2 slow, 3 settled.
  // A step happens once 'gap' cycles have elapsed since the last step/entry.
  int          cyc = 0;
  int          ph, age, gap, nslow;
  int          mv[2];
  logic [15:0] ml;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      ph = 0; age = 0; gap = 4; nslow = 0; ml = 16'hACE1;
      mv[0] = 1; mv[1] = 1;
    end else begin
      automatic bit stepnow = (ph == 1 || ph == 2) && (age == gap - 1);
      if (stepnow)
        for (int i = 0; i < 2; i++)
          if (ml[i]) mv[i] = (mv[i] == 6) ? 1 : mv[i] + 1;
      age = stepnow ? 0 : age + 1;
      case (ph)
        0, 3: begin
          age = 0;
          if (roll) begin ph = 1; gap = 4; end
        end
        1: if (!roll) begin ph = 2; gap = 8; nslow = 0; age = 0; end
        2: begin
          if (roll) begin ph = 1; gap = 4; age = 0; end
          else if (stepnow) begin
            nslow++;
            if (nslow == 3) ph = 3;
            else gap = gap * 2;
          end
        end
        default: ph = 0;
      endcase
      ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
    end
  end

  // Per-cycle compare of the main instance against the model.
  always @(negedge clk) begin
    if (cyc > 0) begin
      check("values", values, {3'(mv[1]), 3'(mv[0])});
      check("pips", pips, {pipof(mv[1]), pipof(mv[0])});
      check("rolling", rolling, (ph == 1 || ph == 2));
      check("settled", settled, (ph == 3));
    end
  end

  // FACES=3 instance: range, pip legality and wrap observation.
  logic [2:0] p3[2];
  bit seen31 = 0, bad456 = 0;
  always @(negedge clk) begin
    if (cyc > 0 && !rst && rolling3) begin
      for (int d = 0; d < 2; d++) begin
        automatic logic [2:0] v = values3[3*d +: 3];
        automatic logic [6:0] pp = pips3[7*d +: 7];
        check("f3_range", (v >= 3'd1 && v <= 3'd3), 1);
        check("f3_pips", pp, pipof(int'(v)));
        if (p3[d] == 3'd3 && v == 3'd1) seen31 = 1;
        if (pp == 7'b1010101 || pp == 7'b1011101 || pp == 7'b1110111) bad456 = 1;
        p3[d] = v;
      end
      check("f3_settled", settled3, 0);
    end else begin
      p3[0] = 3'd0; p3[1] = 3'd0;
    end
  end

  bit watch = 0, saw_settle = 0;
  always @(negedge clk) if (watch && settled) saw_settle = 1;

  task automatic check_reset(input string nm);
    check({nm, "_values"}, values, 6'b001_001);
    check({nm, "_pips"}, pips, 14'b0001000_0001000);
    check({nm, "_rolling"}, rolling, 0);
    check({nm, "_settled"}, settled, 0);
  endtask

  // Release Roll from SPIN; SLOW entry edge plus 8+16+32 cycles to settle.
  task automatic release_and_settle(input string nm);
    int n = 0;
    roll = 1'b0;
    while (n < 300 && settled !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    check(nm, n, 57);
    check({nm, "_rolling"}, rolling, 0);
  endtask

  // First roll after reset: LFSR steps ACE1,59C3,B387,670F,CE1E; the tick
  // on the 5th edge uses CE1E (bits 1:0 = 10) so only die 1 advances.
  task automatic first_roll(input string nm);
    rst = 1'b0; roll = 1'b1;
    @(negedge clk);
    check({nm, "_rolling1"}, rolling, 1);
    check({nm, "_model_lfsr1"}, ml, 16'h59C3);
    repeat (3) @(negedge clk);
    check({nm, "_pre_tick"}, values, 6'b001_001);
    check({nm, "_model_lfsr4"}, ml, 16'hCE1E);
    @(negedge clk);
    check({nm, "_tick_values"}, values, 6'b010_001);
    check({nm, "_tick_pips"}, pips, 14'b1000001_0001000);
  endtask

  initial begin
    rst = 1'b1; roll = 1'b0; roll3 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    roll3 = 1'b1;
    first_roll("roll1");
    repeat (35) @(negedge clk);
    release_and_settle("settle1");
    repeat (100) @(negedge clk);
    check("hold_settled", settled, 1);

    // Re-roll interrupted in SLOW after the first slow tick
    roll = 1'b1;
    repeat (20) @(negedge clk);
    watch = 1; roll = 1'b0;
    repeat (10) @(negedge clk);
    roll = 1'b1;
    repeat (12) @(negedge clk);
    watch = 0;
    check("no_settle_on_reroll", saw_settle, 0);
    release_and_settle("settle2");

    // Reset in SLOW
    roll = 1'b1;
    repeat (20) @(negedge clk);
    roll = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_slow");
    rst = 1'b0; roll = 1'b1;
    repeat (20) @(negedge clk);
    release_and_settle("settle3");
    repeat (5) @(negedge clk);

    // Reset in SETTLED, then identical stimulus reproduces the first roll
    rst = 1'b1; roll = 1'b0;
    @(negedge clk);
    check_reset("rst_settled");
    first_roll("roll2");

    repeat (2000) @(negedge clk);
    check("f3_wrap_seen", seen31, 1);
    check("f3_no_456", bad456, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
